mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the word-address width, which matches the 64KB data memory index.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter STARVE_MAX, default 4, SHALL set the maximum number of consecutive contended port-0 wins before port 1 is forced a slot.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 p0_req, p0_we  input  1 each  SHALL be the CPU port access request and write enable.
REQ-007 p0_addr  input  ADDR_W; p0_wdata  input  DATA_W  SHALL be the CPU port word address and write data.
REQ-008 p0_gnt  output  1; p0_rvalid  output  1; p0_rdata  output  DATA_W  SHALL be the CPU port grant, read-valid and read data.
REQ-009 p1_req, p1_we, p1_lock  input  1 each  SHALL be the debug-loader port request, write enable and bus lock.
REQ-010 p1_addr  input  ADDR_W; p1_wdata  input  DATA_W  SHALL be the debug-loader port word address and write data.
REQ-011 p1_gnt, p1_rvalid  output  1 each; p1_rdata  output  DATA_W  SHALL be the debug-loader port grant, read-valid and read data.
REQ-012 mem_a  output  ADDR_W; mem_we  output  1; mem_d  output  DATA_W  SHALL drive the data memory (synchronous write, asynchronous read).
REQ-013 mem_spo  input  DATA_W  SHALL be the memory's combinational read data.

Function
REQ-014 Grants SHALL be combinational within the cycle; at most one of p0_gnt/p1_gnt SHALL be high in any cycle.
REQ-015 A requester SHALL hold req, we, addr and wdata stable until it sees its gnt; a granted access completes in exactly that cycle.
REQ-016 mem_a, mem_d and mem_we SHALL mux from the granted port; mem_we SHALL be 0 when no port is granted.
REQ-017 For a granted read, the port's rdata SHALL register mem_spo and the port's rvalid SHALL pulse high for one cycle, the cycle after gnt (read latency 1).
REQ-018 The port's rdata SHALL hold its last value when rvalid is low; a write SHALL produce no rvalid.
REQ-019 The FSM SHALL have two states: ARB and LOCK1.
REQ-020 In ARB with only one req high, that port SHALL be granted.
REQ-021 In ARB with both req high, port 0 SHALL win unless starve_cnt equals STARVE_MAX, in which case port 1 SHALL win.
REQ-022 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment on each contended cycle that port 0 wins.
REQ-023 starve_cnt SHALL clear to 0 when port 1 is granted, and SHALL hold in all other cycles, including uncontended port-0 cycles.
REQ-024 ARB->LOCK1 SHALL occur when p1 is granted with p1_lock=1.
REQ-025 In LOCK1, port 1 SHALL be exclusively granted whenever p1_req=1, and p0_gnt SHALL be 0.
REQ-026 LOCK1->ARB SHALL occur at the end of any cycle with p1_lock=0, whether or not a request was issued that cycle.
REQ-027 An uncontended CPU access SHALL add zero wait cycles, so single-cycle CPU timing is preserved when port 1 is idle.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously enter ARB, with starve_cnt=0, p0_rvalid=p1_rvalid=0 and p0_rdata=p1_rdata=0.
REQ-029 A reset asserted mid-lock or with a read outstanding SHALL abort the operation; no rvalid SHALL be produced after rst_n rises for pre-reset accesses.
REQ-030 During reset, gnt and mem_we SHALL be 0.

Structure
REQ-031 The state encoding (ARB, LOCK1) and the default ADDR_W/DATA_W SHALL live in the shared CPU package, alongside the existing control-op constants.
REQ-032 The block SHALL be a single module.
REQ-033 An optional sub-module arb_prio2 (the combinational two-way priority pick with starvation override) is permitted.

Verification
REQ-034 Stimulus: p0 read at addr 0x0010 (mem holds 0xDEADBEEF), p1 idle -> p0_gnt same cycle; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
REQ-035 Stimulus: both ports request continuously -> p0 granted 4 cycles, p1 granted the 5th cycle; pattern repeats with STARVE_MAX=4.
REQ-036 Stimulus: p1 write 0x12345678 to 0x0020 with lock=1, then p1 read at 0x0020 while p0_req=1 -> p0_gnt=0 both cycles; p1_rdata=0x12345678.
REQ-037 Stimulus: p1_lock dropped with p0_req=1 -> p0_gnt=1 in the following cycle.
REQ-038 Stimulus: rst_n pulled low in LOCK1 with a read outstanding -> immediate ARB, all rvalid=0, rdata=0, mem_we=0.
REQ-039 Stimulus: both req=0 -> mem_we=0, no gnt, starve_cnt unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared defaults and state encoding for the data-memory arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU port, debug-loader port and data-memory bus of the arbiter
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_a;
  logic mem_we;
  logic [DATA_W-1:0] mem_d, mem_spo;
  modport slave (
    input p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_lock, p1_addr, p1_wdata, mem_spo,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, mem_a, mem_we, mem_d
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_lock, p1_addr, p1_wdata, mem_spo,
    input p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, mem_a, mem_we, mem_d
  );
endinterface

// File: rtl/mem_arbiter_arb_prio2.sv
// arb_prio2: two-way priority pick, port 0 first unless the starvation override favours port 1
module arb_prio2 (
  input  logic req0,
  input  logic req1,
  input  logic force1,
  output logic gnt0,
  output logic gnt1
);
  // Port 1 wins when alone or when port 0 has starved it long enough
  always_comb begin
    gnt1 = req1 && (!req0 || force1);
    gnt0 = req0 && !gnt1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data memory between the CPU port and a lockable debug-loader port
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic pick0, pick1, p0_gnt, p1_gnt, we, rv0, rv1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rd0, rd1;

  arb_prio2 u_prio (
    .req0(bus.p0_req),
    .req1(bus.p1_req),
    .force1(starve_cnt == SW'(STARVE_MAX)),
    .gnt0(pick0),
    .gnt1(pick1)
  );

  // State register plus count of consecutive contended CPU wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (p1_gnt) starve_cnt <= '0;
      else if (p0_gnt && bus.p1_req) starve_cnt <= starve_cnt + SW'(1);
    end

  // Lock is taken by a granted locked loader access and held while p1_lock stays high
  always_comb
    state_nx = (state == ARB) ? ((p1_gnt && bus.p1_lock) ? LOCK1 : ARB) : (bus.p1_lock ? LOCK1 : ARB);

  // Grants and memory mux; everything is gated off while reset is asserted
  always_comb begin
    p0_gnt = rst_n && state == ARB && pick0;
    p1_gnt = rst_n && (state == LOCK1 ? bus.p1_req : pick1);
    we = p1_gnt ? bus.p1_we : p0_gnt && bus.p0_we;
    addr = p1_gnt ? bus.p1_addr : bus.p0_addr;
    wdata = p1_gnt ? bus.p1_wdata : bus.p0_wdata;
    bus.p0_gnt = p0_gnt;
    bus.p1_gnt = p1_gnt;
    bus.mem_we = we;
    bus.mem_a = addr;
    bus.mem_d = wdata;
  end

  // Read return one cycle after the grant; data holds between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rv0 <= p0_gnt && !bus.p0_we;
      rv1 <= p1_gnt && !bus.p1_we;
      if (p0_gnt && !bus.p0_we) rd0 <= bus.mem_spo;
      if (p1_gnt && !bus.p1_we) rd1 <= bus.mem_spo;
    end

  assign bus.p0_rvalid = rv0;
  assign bus.p1_rvalid = rv1;
  assign bus.p0_rdata = rd0;
  assign bus.p1_rdata = rd1;
endmodule
